// File: rtl/fp_alu_arbiter.sv
// fp_alu_arbiter: round-robin arbiter sequencing NREQ requesters onto one shared Q15 ALU.
// Define FP_ARB_TIMEOUT_EN to add the WAIT watchdog (TIMEOUT_CYC) and rsp_err reporting.
module fp_alu_arbiter #(
    parameter int N           = 32,
    parameter int Q           = 15,
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ*2-1:0] req_op,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_c,
    output logic              rsp_err,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    output logic [1:0]        alu_opcode,
    output logic              alu_start,
    input  logic [N-1:0]      alu_c,
    input  logic              alu_done
);
    if (Q >= N || NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("fp_alu_arbiter: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [IDW-1:0] rr_ptr, cur_id, gnt_id;
    logic gnt_any, timeout, finish;

    function automatic logic [IDW-1:0] wrap(input logic [IDW:0] v);
        return (v >= (IDW+1)'(NREQ)) ? IDW'(v - (IDW+1)'(NREQ)) : IDW'(v);
    endfunction

    // Descending scan so the requester closest to rr_ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[wrap({1'b0, rr_ptr} + (IDW+1)'(k))]) begin
                gnt_any = 1'b1;
                gnt_id  = wrap({1'b0, rr_ptr} + (IDW+1)'(k));
            end
    end

    assign req_ready = (rst_n && state == IDLE && gnt_any) ? NREQ'(1) << gnt_id : '0;
    assign alu_start = state == ISSUE;
    assign rsp_valid = state == RESP;
    assign finish    = state == WAIT && (alu_done || timeout);

`ifdef FP_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    logic [WDW-1:0] wd_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wd_cnt <= '0;
        else        wd_cnt <= (state == WAIT) ? wd_cnt + 1'b1 : '0;
    assign timeout = state == WAIT && !alu_done && wd_cnt == WDW'(TIMEOUT_CYC - 1);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = gnt_any ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = finish ? RESP : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rr_ptr     <= '0;
            cur_id     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_id     <= '0;
            rsp_c      <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (state == IDLE && gnt_any) begin
                alu_a      <= req_a[int'(gnt_id)*N +: N];
                alu_b      <= req_b[int'(gnt_id)*N +: N];
                alu_opcode <= req_op[int'(gnt_id)*2 +: 2];
                cur_id     <= gnt_id;
                rr_ptr     <= wrap({1'b0, gnt_id} + 1'b1);
            end
            if (finish) begin
                rsp_c   <= timeout ? '0 : alu_c;
                rsp_id  <= cur_id;
                rsp_err <= timeout;
            end
        end
endmodule

// File: tb/tb_fp_alu_arbiter.sv
// tb_fp_alu_arbiter: table vectors, corner sequences and randomized traffic checked
// against a transaction-level model of the arbiter and a latency-programmable ALU.
module tb_fp_alu_arbiter;
    localparam int N = 32, NREQ = 4, IDW = 2, TO = 8, NEVER = 1 << 30;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [NREQ-1:0] req_valid, req_ready;
    logic [NREQ*N-1:0] req_a, req_b;
    logic [NREQ*2-1:0] req_op;
    logic rsp_valid, rsp_err, alu_start, alu_done;
    logic [IDW-1:0] rsp_id;
    logic [N-1:0] rsp_c, alu_a, alu_b, alu_c;
    logic [1:0] alu_opcode;

    fp_alu_arbiter #(.N(N), .Q(15), .NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_c(rsp_c), .rsp_err(rsp_err), .alu_a(alu_a), .alu_b(alu_b),
        .alu_opcode(alu_opcode), .alu_start(alu_start), .alu_c(alu_c), .alu_done(alu_done));

    always #5 clk = ~clk;

    logic [N-1:0] ma[NREQ], mb[NREQ];
    logic [1:0] mop[NREQ];
    logic [NREQ-1:0] pend = '0, rearm = '0;
    always_comb begin
        req_valid = pend;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = ma[i];
            req_b[i*N +: N] = mb[i];
            req_op[i*2 +: 2] = mop[i];
        end
    end

    int nvec = 0, nerr = 0, cycle = 0, nrsp = 0;
    int busy = 0, acc = 0, cur = 0, exp_cyc = 0, ptr_m = 0, alu_lat = 3, acnt = 0;
    int last_lat = 0, rand_lat = 0, spur = 0;
    logic [N-1:0] ea, eb, exp_c, ares, last_c, sa, sb;
    logic [1:0] eop, sop;
    logic exp_err, last_err, st;
    int glog[$];

    typedef struct {
        int id; logic [N-1:0] a, b; logic [1:0] op; int lat; logic [N-1:0] c; int cyc;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [N-1:0] alu_f(input logic [N-1:0] a, b, input logic [1:0] op);
        return op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? a & b : a ^ b;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic new_ops(input int i);
        ma[i] = $urandom;
        mb[i] = $urandom;
        mop[i] = 2'($urandom_range(3));
    endtask

    task automatic cyc();
        logic [NREQ-1:0] exp_rdy;
        int g;
        @(negedge clk);
        cycle++;
        g = -1;
        if (busy == 0 && rst_n)
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && pend[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
        exp_rdy = (g >= 0) ? NREQ'(1) << g : '0;
        chk("req_ready", req_ready, exp_rdy);
        chk("alu_start", alu_start, busy != 0 && cycle == acc + 1);
        if (alu_start && busy != 0 && cycle == acc + 1)
            chk("alu_operands", {alu_a, alu_b, alu_opcode}, {ea, eb, eop});
        chk("rsp_valid", rsp_valid, busy != 0 && cycle == acc + exp_cyc);
        if (rsp_valid && busy != 0 && cycle == acc + exp_cyc) begin
            chk("rsp_id", rsp_id, cur);
            chk("rsp_c", rsp_c, exp_c);
            chk("rsp_err", rsp_err, exp_err);
            busy = 0;
            nrsp++;
            last_c = rsp_c;
            last_err = rsp_err;
            last_lat = cycle - acc;
        end
        if (g >= 0) begin
            busy = 1; acc = cycle; cur = g; ptr_m = (g + 1) % NREQ;
            ea = ma[g]; eb = mb[g]; eop = mop[g];
            glog.push_back(g);
            if (rand_lat != 0) alu_lat = $urandom_range(1, 6);
`ifdef FP_ARB_TIMEOUT_EN
            exp_cyc = alu_lat == 0 ? TO + 2 : 3 + alu_lat;
            exp_err = alu_lat == 0;
`else
            exp_cyc = alu_lat == 0 ? NEVER : 3 + alu_lat;
            exp_err = 1'b0;
`endif
            exp_c = alu_lat == 0 ? '0 : alu_f(ea, eb, eop);
        end
        st = alu_start; sa = alu_a; sb = alu_b; sop = alu_opcode;
        @(posedge clk);
        #1;
        if (g >= 0) begin
            if (rearm[g]) new_ops(g);
            else pend[g] = 1'b0;
        end
        if (!rst_n) begin
            acnt = 0;
            alu_done = 1'b0;
        end else begin
            alu_done = spur != 0;
            spur = 0;
            if (st) begin
                acnt = alu_lat;
                ares = alu_f(sa, sb, sop);
            end else if (acnt > 1) acnt--;
            else if (acnt == 1) begin
                acnt = 0;
                alu_done = 1'b1;
                alu_c = ares;
            end
        end
    endtask

    task automatic run_rsp(input int n, input int budget);
        int t = 0;
        while (nrsp < n && t < budget) begin cyc(); t++; end
        chk("rsp_within_budget", nrsp >= n, 1'b1);
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while ((pend != 0 || busy != 0) && t < budget) begin cyc(); t++; end
        chk("drain_idle", {pend, busy != 0}, '0);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        busy = 0; pend = '0; rearm = '0; ptr_m = 0;
        cyc();
        cyc();
        rst_n = 1'b1;
        glog.delete();
    endtask

    initial begin
        int base, t;
        for (int i = 0; i < NREQ; i++) begin ma[i] = '0; mb[i] = '0; mop[i] = '0; end
        alu_c = '0; alu_done = 1'b0;
        vecs[0] = '{0, 32'h0000C000, 32'h00012000, 2'd0, 3, 32'h0001E000, 6};
        vecs[1] = '{2, 32'h00010000, 32'h00008000, 2'd1, 1, 32'h00008000, 4};
        vecs[2] = '{3, 32'hFFFF0000, 32'h0F0F0F0F, 2'd2, 2, 32'h0F0F0000, 5};
        vecs[3] = '{1, 32'h12345678, 32'hFFFFFFFF, 2'd3, 5, 32'hEDCBA987, 8};
        vecs[4] = '{0, 32'h7FFFFFFF, 32'h00000001, 2'd0, 4, 32'h80000000, 7};
        cyc();
        cyc();
        chk("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_c, rsp_err, alu_a, alu_b,
                              alu_opcode, alu_start}, '0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            ma[vecs[i].id] = vecs[i].a; mb[vecs[i].id] = vecs[i].b; mop[vecs[i].id] = vecs[i].op;
            alu_lat = vecs[i].lat;
            pend[vecs[i].id] = 1'b1;
            base = nrsp;
            run_rsp(base + 1, 40);
            chk("table_rsp_c", last_c, vecs[i].c);
            chk("table_latency", last_lat, vecs[i].cyc);
        end

        do_reset();
        alu_lat = 2;
        for (int i = 0; i < NREQ; i++) new_ops(i);
        pend = '1;
        run_rsp(nrsp + 4, 100);
        chk("all4_grant_count", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("all4_grant_order", glog[i], i);

        do_reset();
        new_ops(1); new_ops(3);
        rearm[1] = 1'b1; pend[1] = 1'b1;
        t = 0;
        while (glog.size() < 1 && t < 20) begin cyc(); t++; end
        pend[3] = 1'b1;
        t = 0;
        while (glog.size() < 3 && t < 60) begin cyc(); t++; end
        chk("fair_grants", glog.size(), 3);
        if (glog.size() >= 3) begin
            chk("fair_second", glog[1], 3);
            chk("fair_third", glog[2], 1);
        end
        rearm = '0;
        drain(60);

        do_reset();
        new_ops(1); new_ops(2);
        alu_lat = 1; pend[1] = 1'b1;
        run_rsp(nrsp + 1, 20);
        alu_lat = 20; pend[2] = 1'b1;
        repeat (5) cyc();
        #1 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_c, rsp_err, alu_a,
                                       alu_b, alu_opcode, alu_start}, '0);
        busy = 0; pend = '0; ptr_m = 0;
        cyc();
        cyc();
        rst_n = 1'b1;
        base = nrsp;
        repeat (30) cyc();
        chk("no_rsp_after_reset", nrsp, base);
        base = glog.size();
        alu_lat = 2; pend[1] = 1'b1; pend[3] = 1'b1;
        run_rsp(nrsp + 2, 40);
        if (glog.size() > base) chk("ptr_after_reset", glog[base], 1);

        do_reset();
        alu_lat = 0; pend[0] = 1'b1;
        base = nrsp;
`ifdef FP_ARB_TIMEOUT_EN
        run_rsp(base + 1, 40);
        chk("timeout_err", last_err, 1'b1);
        chk("timeout_c", last_c, '0);
        chk("timeout_latency", last_lat, TO + 2);
`else
        repeat (100) cyc();
        chk("no_timeout_rsp", nrsp, base);
`endif
        do_reset();

        alu_lat = 2;
        repeat (2) cyc();
        spur = 1;
        base = nrsp;
        repeat (6) cyc();
        chk("spurious_done_no_rsp", nrsp, base);
        new_ops(2); pend[2] = 1'b1;
        run_rsp(base + 1, 20);
        chk("spurious_then_normal_id", rsp_id, 2);

        do_reset();
        rand_lat = 1;
        repeat (2500) begin
            cyc();
            for (int i = 0; i < NREQ; i++)
                if (!pend[i] && $urandom_range(3) == 0) begin new_ops(i); pend[i] = 1'b1; end
                else if (pend[i] && $urandom_range(31) == 0) pend[i] = 1'b0;
        end
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/fp_alu_arbiter.md
Name: fp_alu_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one fixed-point ALU (Q15, 32-bit, opcode/start/done_flag protocol) among NREQ requesters.
- Captures one request, pulses the ALU start, waits for done_flag, then returns the result tagged with the requester ID.
- Sits between requester engines and the fp_inf slave-side datapath. One operation in flight at a time.

Parameters:
- N, 32, operand/result width (matches fixed-point format).
- Q, 15, fractional bits; informational only, no arithmetic performed here.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width, equal to clog2(NREQ).
- TIMEOUT_CYC, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request pending; held until accepted.
- req_a  in  NREQ*N  operand A per requester; slice i = [i*N +: N].
- req_b  in  NREQ*N  operand B per requester.
- req_op  in  NREQ*2  opcode per requester.
- req_ready  out  NREQ  one-hot accept pulse; one cycle.
- rsp_valid  out  1  result valid; one-cycle pulse.
- rsp_id  out  IDW  requester index of the result.
- rsp_c  out  N  result value.
- rsp_err  out  1  result is a timeout error (qualified by rsp_valid).
- alu_a  out  N  ALU operand A.
- alu_b  out  N  ALU operand B.
- alu_opcode  out  2  ALU opcode.
- alu_start  out  1  ALU start; one-cycle pulse.
- alu_c  in  N  ALU result.
- alu_done  in  1  ALU done_flag.

Behaviour:
- Reset (async, rst_n low): FSM enters IDLE. rr_ptr=0. All outputs are 0: req_ready, rsp_valid, rsp_id, rsp_c, rsp_err, alu_a, alu_b, alu_opcode, alu_start. Watchdog counter is cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - In that cycle, assert req_ready[g] combinationally.
  - At the clock edge, register req_a/b/op slice g into alu_a/alu_b/alu_opcode, and g into cur_id.
  - Set rr_ptr = (g+1) mod NREQ, then go to ISSUE.
- ISSUE: alu_start=1 for exactly this cycle; operands stable. Go to WAIT.
- WAIT:
  - Hold alu_a/b/opcode stable.
  - On alu_done=1, capture alu_c into rsp_c and go to RESP.
  - alu_done is ignored in IDLE, ISSUE and RESP.
- RESP: rsp_valid=1, rsp_id=cur_id, rsp_err as set. Return to IDLE; a new grant is possible on the next cycle.
- Minimum cycles from accept to rsp_valid: 3 + ALU latency (accept, ISSUE, WAIT≥1, RESP).
- Requester handshake: a requester must keep req_valid and its operands stable until req_ready. Deasserting req_valid before a grant withdraws the request; no response is produced.
- No grant is given while not in IDLE. req_ready is never multi-hot.
- rsp_c/rsp_id/rsp_err hold their last values after the pulse. Consumers must qualify with rsp_valid.
- Reset mid-operation: the in-flight operation is abandoned with no response, and the ALU is left as-is. The bench's ALU model must also be reset.
- rr_ptr wraps from NREQ-1 to 0. Non-power-of-2 NREQ: index values ≥NREQ are unused.

Optional Feature:
- Macro: FP_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT. When it reaches TIMEOUT_CYC cycles without alu_done, go to RESP with rsp_err=1 and rsp_c=0.
  - The counter clears on entering WAIT.
  - A late alu_done after a timeout is ignored.
- Undefined: no counter is present. WAIT waits indefinitely and rsp_err is tied to 0.

Test Plan:
- Single request: req_valid=4'b0001, a=0x0000C000 (1.5), b=0x00012000 (2.25), op=2'b00, bench ALU returns 0x0001E000 after 3 cycles. Required: req_ready[0] one cycle; alu_start one cycle later with matching operands; rsp_valid with rsp_id=0, rsp_c=0x0001E000, rsp_err=0, exactly 6 cycles after accept.
- All four requesting from reset, each held until served. Required: grant order 0,1,2,3; four responses with matching ids; never two req_ready bits high.
- Fairness: requester 1 requests continuously, requester 3 requests once. Required: after 1 is served, 3 is served before 1 is served again.
- Reset mid-WAIT: rst_n low for 2 cycles while waiting. Required: all outputs 0 immediately (async); no rsp_valid afterwards; the next request is served normally starting from rr_ptr=0.
- Timeout with FP_ARB_TIMEOUT_EN and TIMEOUT_CYC=8: ALU never asserts done. Required: rsp_valid with rsp_err=1 and rsp_c=0 after 8 WAIT cycles. Without the macro: no rsp_valid within 100 cycles.
- Spurious alu_done in IDLE: no rsp_valid and no state change.
